// File: rtl/fft_pingpong_ram.sv
// Ping-pong dual-bank RAM for an FFT datapath: one bank is read while the other is written,
// with a bit-reversing sample loader that hands the freshly loaded bank to the read side.
module fft_pingpong_ram #(
    parameter int BIT_WIDTH = 16,
    parameter int N         = 512,
    parameter int M         = 9
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   swap,
    input  logic                   re,
    input  logic [M-1:0]           adr_ra,
    input  logic [M-1:0]           adr_rb,
    input  logic                   we_a,
    input  logic                   we_b,
    input  logic [M-1:0]           adr_wa,
    input  logic [M-1:0]           adr_wb,
    input  logic [2*BIT_WIDTH-1:0] wd_a,
    input  logic [2*BIT_WIDTH-1:0] wd_b,
    input  logic                   load_valid,
    input  logic [2*BIT_WIDTH-1:0] load_data,
    output logic [2*BIT_WIDTH-1:0] rd_a,
    output logic [2*BIT_WIDTH-1:0] rd_b,
    output logic                   rd_valid,
    output logic                   bank_sel,
    output logic                   load_done,
    output logic                   collision
);

    localparam int           W        = 2 * BIT_WIDTH;
    localparam logic [M-1:0] LAST_IDX = M'(N - 1);

    logic [W-1:0] mem [2][N];
    logic [M-1:0] ldcnt;

    logic         wr_bank;
    logic         frame_end;
    logic         toggle;
    logic         slot_a_en;
    logic [M-1:0] slot_a_adr;
    logic [W-1:0] slot_a_data;
    logic         collide;

    function automatic logic [M-1:0] bitrev(input logic [M-1:0] v);
        logic [M-1:0] r;
        r = '0;
        for (int i = 0; i < M; i++) begin
            r[i] = v[M-1-i];
        end
        return r;
    endfunction

    // The loader shares the port A write slot and always takes it over from port A.
    always_comb begin
        wr_bank     = ~bank_sel;
        frame_end   = load_valid && (ldcnt == LAST_IDX);
        toggle      = swap || frame_end;
        slot_a_en   = we_a;
        slot_a_adr  = adr_wa;
        slot_a_data = wd_a;
        if (load_valid) begin
            slot_a_en   = 1'b1;
            slot_a_adr  = bitrev(ldcnt);
            slot_a_data = load_data;
        end
        collide = (load_valid && we_a) ||
                  (slot_a_en && we_b && (slot_a_adr == adr_wb));
    end

    // Port B is issued last so it wins any same-address conflict with the A slot.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (slot_a_en) begin
                mem[wr_bank][slot_a_adr] <= slot_a_data;
            end
            if (we_b) begin
                mem[wr_bank][adr_wb] <= wd_b;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bank_sel  <= 1'b0;
            ldcnt     <= '0;
            load_done <= 1'b0;
            collision <= 1'b0;
        end else begin
            if (toggle) begin
                bank_sel <= ~bank_sel;
            end
            if (load_valid) begin
                ldcnt <= ldcnt + 1'b1;
            end
            load_done <= frame_end;
            collision <= collide;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_a     <= '0;
            rd_b     <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= re;
            if (re) begin
                rd_a <= mem[bank_sel][adr_ra];
                rd_b <= mem[bank_sel][adr_rb];
            end
        end
    end

endmodule

// File: tb/tb_fft_pingpong_ram.sv
// Directed bench for fft_pingpong_ram with N=16: frame load, ping-pong writes,
// write collisions, simultaneous swap, mid-frame reset and read hold.
module tb_fft_pingpong_ram;

    localparam int BW = 16;
    localparam int N  = 16;
    localparam int M  = 4;
    localparam int W  = 2 * BW;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         swap;
    logic         re;
    logic [M-1:0] adr_ra;
    logic [M-1:0] adr_rb;
    logic         we_a;
    logic         we_b;
    logic [M-1:0] adr_wa;
    logic [M-1:0] adr_wb;
    logic [W-1:0] wd_a;
    logic [W-1:0] wd_b;
    logic         load_valid;
    logic [W-1:0] load_data;
    logic [W-1:0] rd_a;
    logic [W-1:0] rd_b;
    logic         rd_valid;
    logic         bank_sel;
    logic         load_done;
    logic         collision;

    int check_count = 0;
    int error_count = 0;
    int done_pulses = 0;

    always #5 clk = ~clk;

    fft_pingpong_ram #(.BIT_WIDTH(BW), .N(N), .M(M)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .swap       (swap),
        .re         (re),
        .adr_ra     (adr_ra),
        .adr_rb     (adr_rb),
        .we_a       (we_a),
        .we_b       (we_b),
        .adr_wa     (adr_wa),
        .adr_wb     (adr_wb),
        .wd_a       (wd_a),
        .wd_b       (wd_b),
        .load_valid (load_valid),
        .load_data  (load_data),
        .rd_a       (rd_a),
        .rd_b       (rd_b),
        .rd_valid   (rd_valid),
        .bank_sel   (bank_sel),
        .load_done  (load_done),
        .collision  (collision)
    );

    task automatic check_output(input string tag, input logic [W-1:0] actual,
                                input logic [W-1:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        swap       = 1'b0;
        re         = 1'b0;
        adr_ra     = '0;
        adr_rb     = '0;
        we_a       = 1'b0;
        we_b       = 1'b0;
        adr_wa     = '0;
        adr_wb     = '0;
        wd_a       = '0;
        wd_b       = '0;
        load_valid = 1'b0;
        load_data  = '0;
    endtask

    task automatic load_sample(input logic [W-1:0] value, input logic with_swap);
        load_valid = 1'b1;
        load_data  = value;
        swap       = with_swap;
        tick();
        load_valid = 1'b0;
        swap       = 1'b0;
        if (load_done) done_pulses++;
    endtask

    task automatic read_pair(input logic [M-1:0] a, input logic [M-1:0] b);
        re     = 1'b1;
        adr_ra = a;
        adr_rb = b;
        tick();
        re     = 1'b0;
    endtask

    initial begin
        clear_inputs();
        reset_n = 1'b0;
        #12;
        check_output("reset bank_sel", W'(bank_sel), 0);
        check_output("reset rd_a", rd_a, 0);
        check_output("reset rd_b", rd_b, 0);
        check_output("reset rd_valid", W'(rd_valid), 0);
        check_output("reset load_done", W'(load_done), 0);
        check_output("reset collision", W'(collision), 0);
        reset_n = 1'b1;

        $display("[TB] frame load");
        done_pulses = 0;
        for (int k = 0; k < N; k++) load_sample(W'(k), 1'b0);
        check_output("s1 bank_sel", W'(bank_sel), 1);
        check_output("s1 load_done", W'(load_done), 1);
        check_output("s1 done count", W'(done_pulses), 1);
        read_pair(4'd1, 4'd8);
        check_output("s1 rd_a", rd_a, 32'd8);
        check_output("s1 rd_b", rd_b, 32'd1);
        check_output("s1 rd_valid", W'(rd_valid), 1);
        check_output("s1 load_done low", W'(load_done), 0);

        $display("[TB] ping-pong write");
        we_a = 1'b1; adr_wa = 4'd3; wd_a = 32'hAAAA5555;
        tick();
        we_a = 1'b0; swap = 1'b1;
        tick();
        swap = 1'b0;
        check_output("s2 bank_sel", W'(bank_sel), 0);
        read_pair(4'd3, 4'd3);
        check_output("s2 rd_a", rd_a, 32'hAAAA5555);
        check_output("s2 rd_b", rd_b, 32'hAAAA5555);
        check_output("s2 rd_valid", W'(rd_valid), 1);

        $display("[TB] read hold");
        adr_ra = 4'd0; adr_rb = 4'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("s6 rd_a hold", rd_a, 32'hAAAA5555);
            check_output("s6 rd_b hold", rd_b, 32'hAAAA5555);
            check_output("s6 rd_valid low", W'(rd_valid), 0);
        end

        $display("[TB] double write");
        we_a = 1'b1; we_b = 1'b1;
        adr_wa = 4'd5; adr_wb = 4'd5; wd_a = 32'd1; wd_b = 32'd2;
        tick();
        check_output("s3 collision", W'(collision), 1);
        adr_wa = 4'd6; adr_wb = 4'd7; wd_a = 32'h66; wd_b = 32'h77;
        tick();
        check_output("s3 no collision", W'(collision), 0);
        we_a = 1'b0; we_b = 1'b0; swap = 1'b1;
        tick();
        swap = 1'b0;
        check_output("s3 bank_sel", W'(bank_sel), 1);
        read_pair(4'd5, 4'd6);
        check_output("s3 addr5", rd_a, 32'd2);
        check_output("s3 addr6", rd_b, 32'h66);
        read_pair(4'd7, 4'd1);
        check_output("s3 addr7", rd_a, 32'h77);
        check_output("s3 addr1 kept", rd_b, 32'd8);

        $display("[TB] simultaneous swap and loader priority");
        done_pulses = 0;
        we_a = 1'b1; adr_wa = 4'd0; wd_a = 32'hDEADBEEF;
        load_sample(32'h100, 1'b0);
        we_a = 1'b0;
        check_output("s4 load vs we_a collision", W'(collision), 1);
        for (int k = 1; k < N - 1; k++) load_sample(W'(32'h100 + k), 1'b0);
        load_sample(32'h10F, 1'b1);
        check_output("s4 bank_sel once", W'(bank_sel), 0);
        check_output("s4 load_done", W'(load_done), 1);
        check_output("s4 done count", W'(done_pulses), 1);
        read_pair(4'd0, 4'd2);
        check_output("s4 addr0 load wins", rd_a, 32'h100);
        check_output("s4 addr2", rd_b, 32'h104);

        $display("[TB] reset mid-frame");
        swap = 1'b1;
        tick();
        swap = 1'b0;
        check_output("s5 pre bank_sel", W'(bank_sel), 1);
        for (int k = 0; k < 7; k++) load_sample(W'(32'h200 + k), 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        check_output("s5 reset bank_sel", W'(bank_sel), 0);
        check_output("s5 reset rd_a", rd_a, 0);
        check_output("s5 reset rd_b", rd_b, 0);
        tick();
        tick();
        #3;
        reset_n = 1'b1;
        done_pulses = 0;
        for (int k = 0; k < N - 1; k++) load_sample(W'(32'h300 + k), 1'b0);
        check_output("s5 no early load_done", W'(done_pulses), 0);
        load_sample(32'h30F, 1'b0);
        check_output("s5 load_done", W'(load_done), 1);
        check_output("s5 bank_sel", W'(bank_sel), 1);
        read_pair(4'd0, 4'd8);
        check_output("s5 addr0 first sample", rd_a, 32'h300);
        check_output("s5 addr8 second sample", rd_b, 32'h301);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
